mem_port_arbiter: RTL and testbench

Sequences the pipeline's single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores). It holds each requester stalled until its access completes, gives MEM priority with a bounded streak so fetch cannot starve, and aborts accesses that never get a bus acknowledge. Its stall outputs feed the same PC-enable and IF/ID load-enable gating that the hazard/forwarding logic drives; the two sources are ORed upstream.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (MEM).
// MEM has priority, but only for a bounded streak of grants; an access that never gets bus_ack is aborted.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT        = 15,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_error
);

  // state    | meaning
  // IDLE     | no access in flight; arbitration happens here
  // BUSY_IF  | fetch access on the bus, waiting for bus_ack
  // BUSY_MEM | load/store access on the bus, waiting for bus_ack
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int STRK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_MEM_STREAK);

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STRK_W-1:0]   streak;
  logic                if_pend, mem_pend;
  logic                grant_if, grant_mem, acked, expired;

  // A requester whose valid is high is stale this cycle and must not be re-granted.
  assign if_pend   = if_req & ~if_valid;
  assign mem_pend  = mem_req & ~mem_valid;
  assign if_stall  = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if)       state_nxt = BUSY_IF;
        else if (grant_mem) state_nxt = BUSY_MEM;
      end
      default: begin
        if (acked | expired) state_nxt = IDLE;
      end
    endcase
  end

  // IF yields to a raw mem_req (even a just-served one) so MEM can build up its streak.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    acked     = 1'b0;
    expired   = 1'b0;
    bus_req   = 1'b0;
    case (state)
      IDLE: begin
        grant_if  = if_pend & (~mem_req | (streak == STRK_MAX));
        grant_mem = ~grant_if & mem_pend;
      end
      BUSY_IF, BUSY_MEM: begin
        bus_req = 1'b1;
        acked   = bus_ack;
        expired = ~bus_ack & (wait_cnt == WAIT_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we    <= 1'b0;
      bus_size  <= 2'b00;
      bus_addr  <= '0;
      bus_wdata <= '0;
      wait_cnt  <= '0;
      streak    <= '0;
    end else begin
      if (grant_if) begin
        bus_we    <= 1'b0;
        bus_size  <= 2'b10;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        wait_cnt  <= '0;
        streak    <= '0;
      end else if (grant_mem) begin
        bus_we    <= mem_we;
        bus_size  <= mem_size;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
        wait_cnt  <= '0;
        if (!if_pend)                streak <= '0;
        else if (streak != STRK_MAX) streak <= streak + STRK_W'(1);
      end else if (bus_req && !bus_ack) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_error <= 1'b0;
    end else begin
      if_valid  <= (state == BUSY_IF) & (acked | expired);
      mem_valid <= (state == BUSY_MEM) & (acked | expired);
      if (state == BUSY_IF) begin
        if (acked)        if_rdata <= bus_rdata;
        else if (expired) if_rdata <= '0;
      end
      if (state == BUSY_MEM) begin
        if (acked && !bus_we) mem_rdata <= bus_rdata;
        else if (expired)     mem_rdata <= '0;
      end
      if (expired) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at the interesting cycles of each scenario.
module tb_mem_port_arbiter;
  localparam int TO = 15;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b10;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid, mem_stall;
  logic        bus_req, bus_we;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_error;

  int n_total = 0;
  int n_pass  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .MAX_MEM_STREAK(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: ack in the ack_lat-th cycle of bus_req (0 = never ack).
  int          ack_lat = 1;
  int          req_cyc = 0;
  logic [31:0] rd_val = '0;
  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      req_cyc++;
      bus_ack = (ack_lat > 0) && (req_cyc == ack_lat);
    end else begin
      req_cyc = 0;
      bus_ack = 1'b0;
    end
    bus_rdata = rd_val;
  end

  // Transaction model: who owns the bus, how long it has waited, and the MEM streak.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_age = 0;
  int          m_streak = 0;
  logic        m_if_valid = 0, m_mem_valid = 0, m_err = 0;
  logic [31:0] m_if_rdata = '0, m_mem_rdata = '0;
  logic        m_we = 0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_age = 0; m_streak = 0;
      m_if_valid = 0; m_mem_valid = 0; m_err = 0;
      m_if_rdata = '0; m_mem_rdata = '0;
      m_we = 0; m_size = '0; m_addr = '0; m_wdata = '0;
    end else begin
      bit ifp, memp;
      ifp  = if_req && !m_if_valid;
      memp = mem_req && !m_mem_valid;
      m_if_valid  = 0;
      m_mem_valid = 0;
      if (m_owner == 0) begin
        if (ifp && (!mem_req || m_streak == MS)) begin
          m_owner = 1; m_age = 0; m_streak = 0;
          m_we = 0; m_size = 2'b10; m_addr = if_addr; m_wdata = '0;
        end else if (memp) begin
          m_owner = 2; m_age = 0;
          m_streak = ifp ? ((m_streak + 1 > MS) ? MS : m_streak + 1) : 0;
          m_we = mem_we; m_size = mem_size; m_addr = mem_addr; m_wdata = mem_wdata;
        end
      end else begin
        m_age++;
        if (bus_ack || m_age == TO) begin
          if (m_owner == 1) begin
            m_if_valid = 1;
            m_if_rdata = bus_ack ? bus_rdata : 32'h0;
          end else begin
            m_mem_valid = 1;
            if (!bus_ack) m_mem_rdata = 32'h0;
            else if (!m_we) m_mem_rdata = bus_rdata;
          end
          if (!bus_ack) m_err = 1;
          m_owner = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_bus_req", bus_req, m_owner != 0);
    check("cmp_if_valid", if_valid, m_if_valid);
    check("cmp_mem_valid", mem_valid, m_mem_valid);
    check("cmp_if_rdata", if_rdata, m_if_rdata);
    check("cmp_mem_rdata", mem_rdata, m_mem_rdata);
    check("cmp_bus_error", bus_error, m_err);
    check("cmp_if_stall", if_stall, if_req && !m_if_valid);
    check("cmp_mem_stall", mem_stall, mem_req && !m_mem_valid);
    check("cmp_bus_we", bus_we, m_we);
    check("cmp_bus_size", bus_size, m_size);
    check("cmp_bus_addr", bus_addr, m_addr);
    check("cmp_bus_wdata", bus_wdata, m_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at edge+1; returns at edge+3 of the valid cycle, or records a failure.
  task automatic wait_valid(input bit want_if, input int budget, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      #2;
      if (want_if ? if_valid : mem_valid) seen = 1;
      else step();
    end
    check(name, seen, 1);
  endtask

  int owners[6];
  int exp_owners[6];
  int ng;
  bit prev_req;

  initial begin
    exp_owners = '{2, 2, 2, 2, 1, 2};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_if_rdata", if_rdata, 0);

    // single fetch, zero-wait
    step(); rd_val = 32'h0050_0093; ack_lat = 1; if_req = 1; if_addr = 32'h40;
    #2; check("t1_c0_stall", if_stall, 1); check("t1_c0_bus_req", bus_req, 0);
    step(); #2;
    check("t1_c1_bus_req", bus_req, 1); check("t1_c1_addr", bus_addr, 32'h40);
    check("t1_c1_size", bus_size, 2'b10); check("t1_c1_stall", if_stall, 1);
    step(); #2;
    check("t1_c2_if_valid", if_valid, 1); check("t1_c2_rdata", if_rdata, 32'h0050_0093);
    check("t1_c2_stall", if_stall, 0); check("t1_c2_bus_req", bus_req, 0);
    step(); if_req = 0;

    // simultaneous requests: MEM first, IF once mem_req drops
    step(); rd_val = 32'h0000_1234; ack_lat = 2;
    if_req = 1; if_addr = 32'h44; mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h100;
    step(); #2; check("t2_c1_addr", bus_addr, 32'h100); check("t2_c1_we", bus_we, 0);
    step(); step(); #2;
    check("t2_c3_mem_valid", mem_valid, 1); check("t2_c3_rdata", mem_rdata, 32'h1234);
    check("t2_c3_if_valid", if_valid, 0);
    step(); mem_req = 0; #2; check("t2_c4_bus_req", bus_req, 0);
    step(); #2;
    check("t2_c5_bus_req", bus_req, 1); check("t2_c5_addr", bus_addr, 32'h44);
    check("t2_c5_size", bus_size, 2'b10);
    rd_val = 32'h0000_5678;
    step(); wait_valid(1, 10, "t2_if_valid_seen");
    check("t2_if_rdata", if_rdata, 32'h5678);
    step(); if_req = 0;

    // bounded MEM streak with IF held
    step(); rd_val = 32'h1111_2222; ack_lat = 1;
    if_req = 1; if_addr = 32'h80; mem_req = 1; mem_addr = 32'h300;
    ng = 0; prev_req = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      #2;
      if (bus_req && !prev_req) begin
        owners[ng] = (bus_addr == 32'h300) ? 2 : 1;
        ng++;
      end
      prev_req = bus_req;
      step();
    end
    check("t3_grant_count", ng, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_owner%0d", i), owners[i], exp_owners[i]);
    wait_valid(0, 10, "t3_last_mem_valid");
    step(); mem_req = 0; if_req = 0;

    // store: attributes pass through, mem_rdata untouched
    step(); rd_val = 32'hDEAD_BEEF; ack_lat = 1;
    mem_req = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h203; mem_wdata = 32'hAB;
    step(); #2;
    check("t4_bus_req", bus_req, 1); check("t4_we", bus_we, 1); check("t4_size", bus_size, 0);
    check("t4_addr", bus_addr, 32'h203); check("t4_wdata", bus_wdata, 32'hAB);
    step(); #2;
    check("t4_mem_valid", mem_valid, 1); check("t4_rdata_kept", mem_rdata, 32'h1111_2222);
    step(); mem_req = 0; mem_we = 0; mem_size = 2'b10;

    // no ack: abort after TIMEOUT busy cycles
    step(); ack_lat = 0; mem_req = 1; mem_addr = 32'h400;
    for (int c = 1; c <= TO; c++) begin
      step(); #2; check($sformatf("t5_busy_c%0d", c), bus_req, 1);
    end
    step(); #2;
    check("t5_abort_bus_req", bus_req, 0); check("t5_abort_valid", mem_valid, 1);
    check("t5_abort_rdata", mem_rdata, 0); check("t5_abort_error", bus_error, 1);
    step(); mem_req = 0;
    step(); ack_lat = 1; rd_val = 32'h0000_0777; if_req = 1; if_addr = 32'h88;
    step(); wait_valid(1, 10, "t5_good_if_valid");
    check("t5_good_rdata", if_rdata, 32'h777); check("t5_error_sticky", bus_error, 1);
    step(); if_req = 0;

    // reset in the middle of a slow fetch
    step(); ack_lat = 5; rd_val = 32'h0BAD_F00D; if_req = 1; if_addr = 32'h90;
    step();
    step(); #1 rst_n = 1'b0; #1;
    check("t6_rst_bus_req", bus_req, 0); check("t6_rst_if_valid", if_valid, 0);
    check("t6_rst_if_rdata", if_rdata, 0); check("t6_rst_error", bus_error, 0);
    step(); rst_n = 1'b1; #2;
    check("t6_rel_bus_req", bus_req, 0);
    step(); #2;
    check("t6_restart_bus_req", bus_req, 1); check("t6_restart_addr", bus_addr, 32'h90);
    step(); wait_valid(1, 12, "t6_if_valid");
    check("t6_if_rdata", if_rdata, 32'h0BAD_F00D);
    step(); if_req = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
